// File: rtl/tm_load_sequencer.sv
// Front-end sequencer: debounces Next/Done, steps PROG->TAPE->RUN->HALT/ERR, strobes words one cycle after a press.
// No backpressure; the optional run watchdog is enabled by TM_WATCHDOG_EN.
module tm_load_sequencer #(
   parameter int NUM_STATES      = 4,
   parameter int TAPE_LEN        = 64,
   parameter int DEBOUNCE_CYCLES = 4,
   parameter int WDOG_CYCLES     = 65535
) (
   input  logic                      clock,
   input  logic                      reset,
   input  logic                      next_in,
   input  logic                      done_in,
   input  logic [5:0]                data_in,
   input  logic                      compute_done,
   output logic                      word_valid,
   output logic [5:0]                word_data,
   output logic                      word_is_tape,
   output logic [$clog2(TAPE_LEN)-1:0] word_addr,
   output logic                      start,
   output logic [2:0]                phase,
   output logic [$clog2(TAPE_LEN):0] tape_len
);

   localparam int AW = $clog2(TAPE_LEN);
   localparam int PW = $clog2(2 * NUM_STATES + 1);
   localparam int DW = $clog2(DEBOUNCE_CYCLES + 1);
   localparam logic [PW-1:0] PROG_WORDS = PW'(2 * NUM_STATES);
   localparam logic [AW:0]   TAPE_WORDS = TAPE_LEN[AW:0];
   localparam logic [DW-1:0] DB_LAST    = DW'(DEBOUNCE_CYCLES - 1);

   typedef enum logic [2:0] {
      S_PROG = 3'd0,
      S_TAPE = 3'd1,
      S_RUN  = 3'd2,
      S_HALT = 3'd3,
      S_ERR  = 3'd4
   } state_t;

   if (DEBOUNCE_CYCLES < 1 || WDOG_CYCLES < 1) begin : g_bad_param
      $error("tm_load_sequencer: DEBOUNCE_CYCLES and WDOG_CYCLES must be >= 1");
   end

   state_t          state_q, state_d;
   logic [PW-1:0]   prog_cnt_q, prog_cnt_d;
   logic [AW:0]     tape_cnt_q, tape_cnt_d;
   logic            word_valid_q, word_valid_d;
   logic [5:0]      word_data_q, word_data_d;
   logic            word_is_tape_q, word_is_tape_d;
   logic [AW-1:0]   word_addr_q, word_addr_d;
   logic            start_q, start_d;
   logic [DW-1:0]   db_cnt_q [2];
   logic [DW-1:0]   db_cnt_d [2];
   logic [1:0]      db_hi_q, db_hi_d;
   logic [1:0]      btn;
   logic [1:0]      press;
   logic            next_ev, done_ev;

`ifdef TM_WATCHDOG_EN
   localparam int WW = $clog2(WDOG_CYCLES + 1);
   localparam logic [WW-1:0] WDOG_LAST = WW'(WDOG_CYCLES - 1);
   logic [WW-1:0]   wdog_q, wdog_d;
`endif

   assign btn = {done_in, next_in};

   // Index 0 = Next, 1 = Done. A level flips only after DEBOUNCE_CYCLES disagreeing samples.
   always_comb begin
      for (int i = 0; i < 2; i++) begin
         db_cnt_d[i] = '0;
         db_hi_d[i]  = db_hi_q[i];
         press[i]    = 1'b0;
         if (btn[i] != db_hi_q[i]) begin
            if (db_cnt_q[i] == DB_LAST) begin
               db_hi_d[i] = btn[i];
               press[i]   = btn[i];
            end else begin
               db_cnt_d[i] = db_cnt_q[i] + 1'b1;
            end
         end
      end
   end

   assign done_ev = press[1];
   assign next_ev = press[0] & ~press[1];

   always_comb begin
      state_d        = state_q;
      prog_cnt_d     = prog_cnt_q;
      tape_cnt_d     = tape_cnt_q;
      word_valid_d   = 1'b0;
      word_data_d    = word_data_q;
      word_is_tape_d = word_is_tape_q;
      word_addr_d    = word_addr_q;
      start_d        = 1'b0;
`ifdef TM_WATCHDOG_EN
      wdog_d         = '0;
`endif
      case (state_q)
         // A full count advances one cycle after the last strobe, so start never overlaps it.
         S_PROG: begin
            if (prog_cnt_q == PROG_WORDS) begin
               state_d = S_TAPE;
            end else if (done_ev) begin
               state_d = S_ERR;
            end else if (next_ev) begin
               word_valid_d   = 1'b1;
               word_data_d    = data_in;
               word_is_tape_d = 1'b0;
               word_addr_d    = AW'(prog_cnt_q);
               prog_cnt_d     = prog_cnt_q + 1'b1;
            end
         end
         S_TAPE: begin
            if (tape_cnt_q == TAPE_WORDS || done_ev) begin
               state_d = S_RUN;
               start_d = 1'b1;
            end else if (next_ev) begin
               word_valid_d   = 1'b1;
               word_data_d    = data_in;
               word_is_tape_d = 1'b1;
               word_addr_d    = tape_cnt_q[AW-1:0];
               tape_cnt_d     = tape_cnt_q + 1'b1;
            end
         end
         S_RUN: begin
            if (compute_done) begin
               state_d = S_HALT;
`ifdef TM_WATCHDOG_EN
            end else if (wdog_q == WDOG_LAST) begin
               state_d = S_ERR;
            end else begin
               wdog_d = wdog_q + 1'b1;
`endif
            end
         end
         S_HALT: begin
            if (done_ev) begin
               state_d    = S_PROG;
               prog_cnt_d = '0;
               tape_cnt_d = '0;
            end else if (next_ev) begin
               state_d = S_RUN;
               start_d = 1'b1;
            end
         end
         S_ERR: begin
            if (done_ev) begin
               state_d    = S_PROG;
               prog_cnt_d = '0;
               tape_cnt_d = '0;
            end
         end
         default: state_d = S_PROG;
      endcase
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         state_q        <= S_PROG;
         prog_cnt_q     <= '0;
         tape_cnt_q     <= '0;
         word_valid_q   <= 1'b0;
         word_data_q    <= '0;
         word_is_tape_q <= 1'b0;
         word_addr_q    <= '0;
         start_q        <= 1'b0;
         db_hi_q        <= '0;
         for (int i = 0; i < 2; i++) db_cnt_q[i] <= '0;
`ifdef TM_WATCHDOG_EN
         wdog_q         <= '0;
`endif
      end else begin
         state_q        <= state_d;
         prog_cnt_q     <= prog_cnt_d;
         tape_cnt_q     <= tape_cnt_d;
         word_valid_q   <= word_valid_d;
         word_data_q    <= word_data_d;
         word_is_tape_q <= word_is_tape_d;
         word_addr_q    <= word_addr_d;
         start_q        <= start_d;
         db_hi_q        <= db_hi_d;
         for (int i = 0; i < 2; i++) db_cnt_q[i] <= db_cnt_d[i];
`ifdef TM_WATCHDOG_EN
         wdog_q         <= wdog_d;
`endif
      end
   end

   assign word_valid   = word_valid_q;
   assign word_data    = word_data_q;
   assign word_is_tape = word_is_tape_q;
   assign word_addr    = word_addr_q;
   assign start        = start_q;
   assign phase        = state_q;
   assign tape_len     = tape_cnt_q;

endmodule

// File: tb/tb_tm_load_sequencer.sv
// Directed bench for tm_load_sequencer; inputs driven and outputs sampled on the falling edge.
module tb_tm_load_sequencer;

   logic       clock = 1'b0;
   logic       reset, next_in, done_in, compute_done;
   logic [5:0] data_in;
   logic       word_valid, word_is_tape, start;
   logic [5:0] word_data, word_addr;
   logic [2:0] phase;
   logic [6:0] tape_len;

   int total = 0;
   int bad   = 0;

   always #5 clock = ~clock;

   tm_load_sequencer #(.WDOG_CYCLES(16)) dut (
      .clock(clock), .reset(reset), .next_in(next_in), .done_in(done_in),
      .data_in(data_in), .compute_done(compute_done), .word_valid(word_valid),
      .word_data(word_data), .word_is_tape(word_is_tape), .word_addr(word_addr),
      .start(start), .phase(phase), .tape_len(tape_len)
   );

   typedef struct packed {
      logic       tape;
      logic [5:0] addr;
      logic [5:0] dat;
      logic [2:0] ph;
   } strobe_t;

   strobe_t    sq[$];
   int         start_cnt   = 0;
   int         overlap_cnt = 0;
   int         run_cycles  = 0;
   logic [2:0] start_phase = 3'd7;

   // Recorder only: logs every strobe/start so scenarios can compare against their own tables.
   always @(negedge clock) begin
      if (word_valid) sq.push_back({word_is_tape, word_addr, word_data, phase});
      if (start) begin
         start_cnt   = start_cnt + 1;
         start_phase = phase;
      end
      if (start && word_valid) overlap_cnt = overlap_cnt + 1;
      if (phase == 3'd2) run_cycles = run_cycles + 1;
   end

   task automatic press(input logic nx, input logic dn, input int hold, input logic [5:0] d);
      @(negedge clock);
      data_in = d; next_in = nx; done_in = dn;
      repeat (hold) @(negedge clock);
      next_in = 1'b0; done_in = 1'b0;
      repeat (6) @(negedge clock);
   endtask

   task automatic load_program(input logic [5:0] base);
      for (int i = 0; i < 8; i++) press(1'b1, 1'b0, 4, base + i[5:0]);
   endtask

   task automatic halt_and_clear();
      @(negedge clock); compute_done = 1'b1;
      @(negedge clock); compute_done = 1'b0;
      press(1'b0, 1'b1, 4, 6'h00);
   endtask

   task automatic test_reset();
      reset = 1'b1; next_in = 1'b0; done_in = 1'b0; data_in = '0; compute_done = 1'b0;
      repeat (3) @(negedge clock);
      total++; if (phase !== 3'd0) begin bad++; $display("FAIL reset_phase got=%0d exp=0", phase); end
      total++; if (word_valid !== 1'b0 || start !== 1'b0) begin bad++; $display("FAIL reset_strobes got=%b%b exp=00", word_valid, start); end
      total++; if (word_data !== 6'h00 || word_addr !== 6'h00 || word_is_tape !== 1'b0) begin bad++; $display("FAIL reset_word got=%h/%h/%b exp=0/0/0", word_data, word_addr, word_is_tape); end
      total++; if (tape_len !== 7'd0) begin bad++; $display("FAIL reset_tape_len got=%0d exp=0", tape_len); end
      reset = 1'b0;
   endtask

   task automatic test_debounce();
      int n0 = sq.size();
      press(1'b1, 1'b0, 3, 6'h11);
      total++; if (sq.size() !== n0) begin bad++; $display("FAIL db_short got=%0d exp=%0d", sq.size(), n0); end
      press(1'b1, 1'b0, 4, 6'h01);
      total++; if (sq.size() !== n0 + 1) begin bad++; $display("FAIL db_four_count got=%0d exp=%0d", sq.size(), n0 + 1); end
      else begin
         total++; if (sq[n0].addr !== 6'd0 || sq[n0].dat !== 6'h01 || sq[n0].tape !== 1'b0) begin bad++; $display("FAIL db_four_word got=%h/%h/%b exp=0/01/0", sq[n0].addr, sq[n0].dat, sq[n0].tape); end
      end
      press(1'b1, 1'b0, 100, 6'h02);
      total++; if (sq.size() !== n0 + 2) begin bad++; $display("FAIL db_long_count got=%0d exp=%0d", sq.size(), n0 + 2); end
      else begin
         total++; if (sq[n0 + 1].addr !== 6'd1) begin bad++; $display("FAIL db_long_addr got=%0d exp=1", sq[n0 + 1].addr); end
      end
      @(negedge clock); reset = 1'b1;
      @(negedge clock); reset = 1'b0;
   endtask

   task automatic test_program();
      int n0 = sq.size();
      load_program(6'h01);
      total++; if (sq.size() !== n0 + 8) begin bad++; $display("FAIL prog_count got=%0d exp=%0d", sq.size(), n0 + 8); end
      else begin
         for (int i = 0; i < 8; i++) begin
            total++;
            if (sq[n0 + i] !== {1'b0, i[5:0], i[5:0] + 6'd1, 3'd0}) begin
               bad++; $display("FAIL prog_word%0d got=%h exp=%h", i, sq[n0 + i], {1'b0, i[5:0], i[5:0] + 6'd1, 3'd0});
            end
         end
      end
      total++; if (phase !== 3'd1) begin bad++; $display("FAIL prog_to_tape got=%0d exp=1", phase); end
   endtask

   task automatic test_tape_run();
      logic [5:0] tv [3] = '{6'h2A, 6'h15, 6'h3F};
      int n0 = sq.size();
      int s0 = start_cnt;
      for (int i = 0; i < 3; i++) press(1'b1, 1'b0, 4, tv[i]);
      total++; if (sq.size() !== n0 + 3) begin bad++; $display("FAIL tape_count got=%0d exp=%0d", sq.size(), n0 + 3); end
      else begin
         for (int i = 0; i < 3; i++) begin
            total++;
            if (sq[n0 + i] !== {1'b1, i[5:0], tv[i], 3'd1}) begin
               bad++; $display("FAIL tape_word%0d got=%h exp=%h", i, sq[n0 + i], {1'b1, i[5:0], tv[i], 3'd1});
            end
         end
      end
      press(1'b0, 1'b1, 4, 6'h00);
      total++; if (phase !== 3'd2) begin bad++; $display("FAIL tape_done_phase got=%0d exp=2", phase); end
      total++; if (tape_len !== 7'd3) begin bad++; $display("FAIL tape_len got=%0d exp=3", tape_len); end
      total++; if (start_cnt !== s0 + 1 || start_phase !== 3'd2) begin bad++; $display("FAIL run_start got=%0d@%0d exp=%0d@2", start_cnt - s0, start_phase, 1); end
      total++; if (sq.size() !== n0 + 3) begin bad++; $display("FAIL done_no_strobe got=%0d exp=%0d", sq.size(), n0 + 3); end
      @(negedge clock); compute_done = 1'b1;
      @(negedge clock);
      total++; if (phase !== 3'd3) begin bad++; $display("FAIL halt_phase got=%0d exp=3", phase); end
      compute_done = 1'b0;
      total++; if (tape_len !== 7'd3) begin bad++; $display("FAIL halt_tape_len got=%0d exp=3", tape_len); end
   endtask

   task automatic test_rerun();
      int n0 = sq.size();
      int s0 = start_cnt;
      press(1'b1, 1'b0, 4, 6'h33);
      total++; if (phase !== 3'd2 || start_cnt !== s0 + 1) begin bad++; $display("FAIL rerun got=phase%0d starts%0d exp=phase2 starts1", phase, start_cnt - s0); end
      total++; if (sq.size() !== n0 || tape_len !== 7'd3) begin bad++; $display("FAIL rerun_counts got=%0d/%0d exp=%0d/3", sq.size(), tape_len, n0); end
      halt_and_clear();
      total++; if (phase !== 3'd0 || tape_len !== 7'd0) begin bad++; $display("FAIL halt_done got=%0d/%0d exp=0/0", phase, tape_len); end
   endtask

   task automatic test_simultaneous();
      int n0, s0;
      load_program(6'h10);
      n0 = sq.size(); s0 = start_cnt;
      press(1'b1, 1'b1, 4, 6'h3F);
      total++; if (sq.size() !== n0) begin bad++; $display("FAIL simul_strobe got=%0d exp=%0d", sq.size(), n0); end
      total++; if (phase !== 3'd2 || start_cnt !== s0 + 1 || tape_len !== 7'd0) begin bad++; $display("FAIL simul_run got=%0d/%0d/%0d exp=2/1/0", phase, start_cnt - s0, tape_len); end
      halt_and_clear();
   endtask

   task automatic test_error();
      int n0 = sq.size();
      for (int i = 0; i < 5; i++) press(1'b1, 1'b0, 4, 6'h20 + i[5:0]);
      press(1'b0, 1'b1, 4, 6'h00);
      total++; if (phase !== 3'd4) begin bad++; $display("FAIL err_phase got=%0d exp=4", phase); end
      press(1'b1, 1'b0, 4, 6'h21);
      total++; if (phase !== 3'd4 || sq.size() !== n0 + 5) begin bad++; $display("FAIL err_next got=%0d/%0d exp=4/%0d", phase, sq.size(), n0 + 5); end
      press(1'b0, 1'b1, 4, 6'h00);
      total++; if (phase !== 3'd0) begin bad++; $display("FAIL err_clear got=%0d exp=0", phase); end
      press(1'b1, 1'b0, 4, 6'h07);
      total++; if (sq.size() !== n0 + 6) begin bad++; $display("FAIL err_restart_count got=%0d exp=%0d", sq.size(), n0 + 6); end
      else begin
         total++; if (sq[n0 + 5].addr !== 6'd0 || sq[n0 + 5].dat !== 6'h07) begin bad++; $display("FAIL err_restart_word got=%h/%h exp=0/07", sq[n0 + 5].addr, sq[n0 + 5].dat); end
      end
   endtask

   task automatic test_reset_mid();
      int n0 = sq.size();
      @(negedge clock); next_in = 1'b1; data_in = 6'h2B;
      repeat (3) @(negedge clock);
      reset = 1'b1;
      @(negedge clock);
      total++; if (word_valid !== 1'b0 || phase !== 3'd0) begin bad++; $display("FAIL mid_reset got=%b/%0d exp=0/0", word_valid, phase); end
      reset = 1'b0; next_in = 1'b0;
      repeat (6) @(negedge clock);
      press(1'b1, 1'b0, 4, 6'h2C);
      total++; if (sq.size() !== n0 + 1) begin bad++; $display("FAIL mid_reset_count got=%0d exp=%0d", sq.size(), n0 + 1); end
      else begin
         total++; if (sq[n0].addr !== 6'd0 || sq[n0].dat !== 6'h2C) begin bad++; $display("FAIL mid_reset_word got=%h/%h exp=0/2C", sq[n0].addr, sq[n0].dat); end
      end
      @(negedge clock); reset = 1'b1;
      @(negedge clock); reset = 1'b0;
   endtask

   task automatic test_tape_full();
      int n0, s0, ov0;
      load_program(6'h00);
      n0 = sq.size(); s0 = start_cnt; ov0 = overlap_cnt;
      for (int i = 0; i < 64; i++) press(1'b1, 1'b0, 4, 6'h3F - i[5:0]);
      total++; if (sq.size() !== n0 + 64) begin bad++; $display("FAIL full_count got=%0d exp=%0d", sq.size(), n0 + 64); end
      else begin
         for (int i = 0; i < 64; i++) begin
            total++;
            if (sq[n0 + i] !== {1'b1, i[5:0], 6'h3F - i[5:0], 3'd1}) begin
               bad++; $display("FAIL full_word%0d got=%h exp=%h", i, sq[n0 + i], {1'b1, i[5:0], 6'h3F - i[5:0], 3'd1});
            end
         end
      end
      total++; if (phase !== 3'd2 || start_cnt !== s0 + 1) begin bad++; $display("FAIL full_auto_run got=%0d/%0d exp=2/1", phase, start_cnt - s0); end
      total++; if (overlap_cnt !== ov0) begin bad++; $display("FAIL full_overlap got=%0d exp=%0d", overlap_cnt, ov0); end
      total++; if (tape_len !== 7'd64) begin bad++; $display("FAIL full_tape_len got=%0d exp=64", tape_len); end
      halt_and_clear();
   endtask

   task automatic test_watchdog();
      int r0;
      load_program(6'h05);
      r0 = run_cycles;
      press(1'b0, 1'b1, 4, 6'h00);
      repeat (40) @(negedge clock);
`ifdef TM_WATCHDOG_EN
      total++; if (phase !== 3'd4) begin bad++; $display("FAIL wdog_phase got=%0d exp=4", phase); end
      total++; if (run_cycles - r0 !== 16) begin bad++; $display("FAIL wdog_cycles got=%0d exp=16", run_cycles - r0); end
`else
      total++; if (phase !== 3'd2) begin bad++; $display("FAIL nowdog_phase got=%0d exp=2", phase); end
      total++; if ((run_cycles - r0 > 40) !== 1'b1) begin bad++; $display("FAIL nowdog_cycles got=%0d exp>40", run_cycles - r0); end
`endif
   endtask

   initial begin
      test_reset();
      test_debounce();
      test_program();
      test_tape_run();
      test_rerun();
      test_simultaneous();
      test_error();
      test_reset_mid();
      test_tape_full();
      test_watchdog();
      total++; if (overlap_cnt !== 0) begin bad++; $display("FAIL strobe_start_overlap got=%0d exp=0", overlap_cnt); end
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
